obi_uart_irq_moderator: RTL and testbench
=========================================

// Module: obi_uart_irq_moderator
// PURPOSE
// - Interrupt moderation controller between the UART interrupt block (level irq + ISR id) and the CPU irq line.
// - Coalesces bursts of UART interrupt events, enforces a min. gap (holdoff) between CPU irqs, forwards urgent ones.
// - Configured from UART CSRs; tick_i comes from the baud prescaler; ack_i pulses on an OBI read of ISR.
// PARAMETERS
// - TimerWidth  16  width of holdoff/collect timer, counted in tick_i pulses
// - CountWidth  4   width of coalesced-event counter and threshold
// PORTS
// - clk_i            in   1           clock
// - rst_ni           in   1           asynchronous active-low reset
// - tick_i           in   1           timer tick, 1-cycle pulse
// - irq_raw_i        in   1           level interrupt from the UART interrupt block
// - isr_id_i         in   3           current ISR id (3'b011 = RLS, urgent)
// - ack_i            in   1           CPU read of ISR, 1-cycle pulse
// - cfg_en_i         in   1           0: bypass, 1: moderate
// - cfg_holdoff_i    in   TimerWidth  collect window and holdoff length in ticks
// - cfg_thresh_i     in   CountWidth  events that force an immediate irq
// - irq_o            out  1           moderated irq, active high, registered
// - irq_no           out  1           ~irq_o
// - evt_cnt_o        out  CountWidth  events coalesced so far
// - stats_irq_cnt_o  out  16          irqs raised (optional feature)
// BEHAVIOUR
// - Reset: state IDLE, irq_o=0, irq_no=1, evt_cnt_o=0, timer=0, stats=0.
// - Event (evt): rising edge of irq_raw_i, or isr_id_i changes while irq_raw_i=1 (registered prev values).
// - urgent = irq_raw_i & (isr_id_i==3'b011).
// - Bypass (cfg_en_i=0): irq_o = irq_raw_i (comb). FSM forced to IDLE next cycle; counters cleared.
// - IDLE:    evt & (urgent | cfg_thresh_i<=1 | cfg_holdoff_i==0) -> ASSERT;
//            evt otherwise -> COLLECT, cnt=1, timer=cfg_holdoff_i.
// - COLLECT: cnt+1 per evt, saturates at all-ones; timer-1 per tick_i.
//            -> ASSERT if urgent | cnt(next)>=cfg_thresh_i | (tick_i & timer==1).
//            -> IDLE (cnt=0) if irq_raw_i=0 (cause removed before irq raised).
// - ASSERT:  irq_o=1. ack_i | ~irq_raw_i -> HOLDOFF, timer=cfg_holdoff_i, cnt=0.
// - HOLDOFF: irq_o=0; evt counted into cnt; timer-1 per tick_i. Urgent does NOT bypass holdoff.
//            timer==0, or tick_i & timer==1: irq_raw_i=1 -> COLLECT (cnt=max(cnt,1), reload timer), else IDLE (cnt=0).
// - Latency: FSM transition effective next cycle; irq_o=(state==ASSERT), 1 cycle after the triggering evt.
// - Priority in a cycle: ~cfg_en_i > exit conditions > evt counting. ack_i+evt in ASSERT: -> HOLDOFF, cnt=1.
// - Timer never underflows; tick_i with timer==0 is ignored.
// - ack_i outside ASSERT is ignored.
// - cfg changes take effect at the next timer/threshold compare; no re-arm of a running timer.
// - evt_cnt_o = cnt register.
// CONFIGURATION
// - OBI_UART_IRQ_MOD_STATS_EN defined: stats_irq_cnt_o counts IDLE/COLLECT/HOLDOFF->ASSERT entries,
//   16 bit, saturating at 16'hFFFF, cleared only by reset; bypass-mode irqs not counted.
// - Undefined: stats_irq_cnt_o tied to 16'h0, no counter flops.
// TESTING
// - Reset mid-ASSERT: rst_ni low async -> irq_o=0, irq_no=1, evt_cnt_o=0 immediately, no clock needed.
// - Bypass: cfg_en=0, irq_raw_i pulses 3 cycles -> irq_o mirrors irq_raw_i exactly, evt_cnt_o stays 0.
// - Coalescing: cfg_en=1, holdoff=100, thresh=4; 4 evts 2 ticks apart -> irq_o=1 one cycle after 4th evt.
// - Window expiry: holdoff=5, thresh=8, 1 evt (rxdr id 3'b010) -> irq_o=1 exactly 1 cycle after 5th tick.
// - Urgent: in COLLECT with cnt=1, isr_id_i->3'b011 -> irq_o=1 next cycle; in HOLDOFF it waits out the timer.
// - Holdoff: ack_i in ASSERT, holdoff=3, irq_raw_i stays 1 -> irq_o=0 for 3 ticks, then COLLECT, irq again.

Source files
------------

// File: rtl/obi_uart_irq_moderator_if.sv
// Interrupt-path bundle between the UART interrupt block, the moderator and the CPU.
// Signals: irq_raw_i/isr_id_i/ack_i (UART side -> moderator), irq_o/irq_no (moderator -> CPU).
// master: the UART/CPU environment that drives the raw irq; slave: the moderator.
interface obi_uart_irq_moderator_if;
  logic       irq_raw_i;
  logic [2:0] isr_id_i;
  logic       ack_i;
  logic       irq_o;
  logic       irq_no;

  modport master (output irq_raw_i, isr_id_i, ack_i, input irq_o, irq_no);
  modport slave  (input irq_raw_i, isr_id_i, ack_i, output irq_o, irq_no);
endinterface

// File: rtl/obi_uart_irq_moderator.sv
// Interrupt moderation between the UART irq block and the CPU: coalesces events, enforces holdoff, forwards urgent RLS.
// Latency: irq_o rises one cycle after the triggering event (combinational pass-through in bypass mode).
// Backpressure: none; ack_i (ISR read) closes an asserted irq and starts the holdoff window.
// Ports: clk_i/rst_ni, tick_i (prescaler tick), uart (irq_raw_i, isr_id_i, ack_i, irq_o, irq_no),
//        cfg_en_i/cfg_holdoff_i/cfg_thresh_i, evt_cnt_o (coalesced events), stats_irq_cnt_o.
// Optional: define OBI_UART_IRQ_MOD_STATS_EN to build the saturating irq statistics counter.
module obi_uart_irq_moderator #(
  parameter int unsigned TimerWidth = 16,
  parameter int unsigned CountWidth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tick_i,
  obi_uart_irq_moderator_if.slave uart,
  input  logic                  cfg_en_i,
  input  logic [TimerWidth-1:0] cfg_holdoff_i,
  input  logic [CountWidth-1:0] cfg_thresh_i,
  output logic [CountWidth-1:0] evt_cnt_o,
  output logic [15:0]           stats_irq_cnt_o
);

  localparam logic [2:0] IsrIdRls = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_ASSERT,
    S_HOLDOFF
  } state_e;

  state_e                state_q, state_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  prev_raw_q, prev_raw_d;
  logic [2:0]            prev_id_q, prev_id_d;

  logic                  evt;
  logic                  urgent;
  logic [CountWidth-1:0] cnt_evt;
  logic [TimerWidth-1:0] timer_dec;
  logic                  timer_exp;

  // A new cause is either a fresh rising edge or the UART switching to a different ISR id while still pending.
  assign evt    = uart.irq_raw_i & (~prev_raw_q | (uart.isr_id_i != prev_id_q));
  assign urgent = uart.irq_raw_i & (uart.isr_id_i == IsrIdRls);

  assign prev_raw_d = uart.irq_raw_i;
  assign prev_id_d  = uart.isr_id_i;

  // Saturating event count and non-underflowing tick countdown, shared by all states.
  assign cnt_evt   = (evt && (cnt_q != '1)) ? cnt_q + CountWidth'(1) : cnt_q;
  assign timer_dec = (tick_i && (timer_q != '0)) ? timer_q - TimerWidth'(1) : timer_q;
  assign timer_exp = tick_i && (timer_q == TimerWidth'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;

    if (!cfg_en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (evt) begin
            cnt_d = CountWidth'(1);
            if (urgent || (cfg_thresh_i <= CountWidth'(1)) || (cfg_holdoff_i == '0)) begin
              state_d = S_ASSERT;
            end else begin
              state_d = S_COLLECT;
              timer_d = cfg_holdoff_i;
            end
          end
        end

        S_COLLECT: begin
          if (!uart.irq_raw_i) begin
            // Cause went away before the CPU ever saw it.
            state_d = S_IDLE;
            cnt_d   = '0;
            timer_d = '0;
          end else begin
            cnt_d   = cnt_evt;
            timer_d = timer_dec;
            if (urgent || (cnt_evt >= cfg_thresh_i) || timer_exp) begin
              state_d = S_ASSERT;
            end
          end
        end

        S_ASSERT: begin
          if (uart.ack_i || !uart.irq_raw_i) begin
            state_d = S_HOLDOFF;
            timer_d = cfg_holdoff_i;
            // An event landing on the ack cycle is the first one of the next batch.
            cnt_d   = evt ? CountWidth'(1) : '0;
          end else begin
            cnt_d = cnt_evt;
          end
        end

        S_HOLDOFF: begin
          if ((timer_q == '0) || timer_exp) begin
            if (uart.irq_raw_i) begin
              state_d = S_COLLECT;
              cnt_d   = (cnt_q == '0) ? CountWidth'(1) : cnt_q;
              timer_d = cfg_holdoff_i;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
              timer_d = '0;
            end
          end else begin
            // Urgent causes are only counted here; the gap between CPU irqs is absolute.
            cnt_d   = cnt_evt;
            timer_d = timer_dec;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      prev_raw_q <= 1'b0;
      prev_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      prev_raw_q <= prev_raw_d;
      prev_id_q  <= prev_id_d;
    end
  end

  assign uart.irq_o  = cfg_en_i ? (state_q == S_ASSERT) : uart.irq_raw_i;
  assign uart.irq_no = ~uart.irq_o;
  assign evt_cnt_o   = cnt_q;

`ifdef OBI_UART_IRQ_MOD_STATS_EN
  logic [15:0] stats_q, stats_d;

  // Counts moderated irq entries only; bypass never enters S_ASSERT.
  always_comb begin
    stats_d = stats_q;
    if (cfg_en_i && (state_d == S_ASSERT) && (state_q != S_ASSERT) && (stats_q != 16'hFFFF)) begin
      stats_d = stats_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign stats_irq_cnt_o = stats_q;
`else
  assign stats_irq_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_obi_uart_irq_moderator.sv
// Directed bench for obi_uart_irq_moderator: reset, bypass, coalescing, window expiry, urgent, holdoff, saturation.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point, before new stimulus.
// Expected values are hand-derived from the moderation rules.
module tb_obi_uart_irq_moderator;

  logic        clk_i;
  logic        rst_ni;
  logic        tick_i;
  logic        cfg_en_i;
  logic [15:0] cfg_holdoff_i;
  logic [3:0]  cfg_thresh_i;
  logic [3:0]  evt_cnt_o;
  logic [15:0] stats_irq_cnt_o;

  int n_checks;
  int n_fail;

  obi_uart_irq_moderator_if u_if ();

  obi_uart_irq_moderator #(
    .TimerWidth(16),
    .CountWidth(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tick_i         (tick_i),
    .uart           (u_if),
    .cfg_en_i       (cfg_en_i),
    .cfg_holdoff_i  (cfg_holdoff_i),
    .cfg_thresh_i   (cfg_thresh_i),
    .evt_cnt_o      (evt_cnt_o),
    .stats_irq_cnt_o(stats_irq_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic tick_once();
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0;
  endtask

  task automatic go_idle();
    u_if.irq_raw_i = 1'b0;
    u_if.ack_i     = 1'b0;
    tick_i         = 1'b0;
    cfg_en_i       = 1'b0;
    cyc(1);
    cfg_en_i = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", u_if.irq_o); n_fail++; end
    n_checks++; if (u_if.irq_no !== 1'b1) begin $display("FAIL reset_irq_n: got %b expected 1", u_if.irq_no); n_fail++; end
    n_checks++; if (evt_cnt_o !== 4'd0) begin $display("FAIL reset_cnt: got %0d expected 0", evt_cnt_o); n_fail++; end
    n_checks++; if (stats_irq_cnt_o !== 16'd0) begin $display("FAIL reset_stats: got %0d expected 0", stats_irq_cnt_o); n_fail++; end
    #4 rst_ni = 1'b1;
    cyc(1);
    // Drive into ASSERT, then pull reset between clock edges.
    cfg_holdoff_i = 16'd10; cfg_thresh_i = 4'd1;
    u_if.irq_raw_i = 1'b1; u_if.isr_id_i = 3'b010;
    cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b1) begin $display("FAIL pre_reset_assert: got %b expected 1", u_if.irq_o); n_fail++; end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL async_reset_irq: got %b expected 0", u_if.irq_o); n_fail++; end
    n_checks++; if (u_if.irq_no !== 1'b1) begin $display("FAIL async_reset_irq_n: got %b expected 1", u_if.irq_no); n_fail++; end
    n_checks++; if (evt_cnt_o !== 4'd0) begin $display("FAIL async_reset_cnt: got %0d expected 0", evt_cnt_o); n_fail++; end
    u_if.irq_raw_i = 1'b0;
    #2 rst_ni = 1'b1;
    cyc(1);
  endtask

  task automatic test_bypass();
    cfg_en_i = 1'b0;
    u_if.irq_raw_i = 1'b1; u_if.isr_id_i = 3'b010;
    #1;
    n_checks++; if (u_if.irq_o !== 1'b1) begin $display("FAIL bypass_comb_rise: got %b expected 1", u_if.irq_o); n_fail++; end
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_checks++; if (u_if.irq_o !== 1'b1) begin $display("FAIL bypass_high[%0d]: got %b expected 1", i, u_if.irq_o); n_fail++; end
      n_checks++; if (evt_cnt_o !== 4'd0) begin $display("FAIL bypass_cnt[%0d]: got %0d expected 0", i, evt_cnt_o); n_fail++; end
    end
    u_if.irq_raw_i = 1'b0;
    #1;
    n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL bypass_comb_fall: got %b expected 0", u_if.irq_o); n_fail++; end
    n_checks++; if (u_if.irq_no !== 1'b1) begin $display("FAIL bypass_irq_n: got %b expected 1", u_if.irq_no); n_fail++; end
    cyc(1);
    cfg_en_i = 1'b1;
    cyc(1);
  endtask

  task automatic test_coalesce();
    logic [2:0] ids [4];
    ids[0] = 3'b010; ids[1] = 3'b110; ids[2] = 3'b010; ids[3] = 3'b110;
    cfg_holdoff_i = 16'd100; cfg_thresh_i = 4'd4;
    u_if.irq_raw_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.isr_id_i = ids[i];
      cyc(1);
      n_checks++; if (u_if.irq_o !== (i == 3)) begin $display("FAIL coalesce_irq[%0d]: got %b expected %b", i, u_if.irq_o, (i == 3)); n_fail++; end
      n_checks++; if (evt_cnt_o !== 4'(i + 1)) begin $display("FAIL coalesce_cnt[%0d]: got %0d expected %0d", i, evt_cnt_o, i + 1); n_fail++; end
      if (i == 1) begin
        // ack outside ASSERT has no effect
        u_if.ack_i = 1'b1; cyc(1); u_if.ack_i = 1'b0;
        n_checks++; if (evt_cnt_o !== 4'd2) begin $display("FAIL stray_ack_cnt: got %0d expected 2", evt_cnt_o); n_fail++; end
      end
      if (i < 3) begin tick_once(); tick_once(); end
    end
    n_checks++; if (u_if.irq_no !== 1'b0) begin $display("FAIL coalesce_irq_n: got %b expected 0", u_if.irq_no); n_fail++; end
    u_if.ack_i = 1'b1; cyc(1); u_if.ack_i = 1'b0;
    n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL coalesce_ack: got %b expected 0", u_if.irq_o); n_fail++; end
    n_checks++; if (evt_cnt_o !== 4'd0) begin $display("FAIL coalesce_ack_cnt: got %0d expected 0", evt_cnt_o); n_fail++; end
    go_idle();
  endtask

  task automatic test_window();
    cfg_holdoff_i = 16'd5; cfg_thresh_i = 4'd8;
    u_if.irq_raw_i = 1'b1; u_if.isr_id_i = 3'b010;
    cyc(1);
    n_checks++; if (evt_cnt_o !== 4'd1) begin $display("FAIL window_cnt: got %0d expected 1", evt_cnt_o); n_fail++; end
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      tick_once();
      n_checks++; if (u_if.irq_o !== (i == 5)) begin $display("FAIL window_tick[%0d]: got %b expected %b", i, u_if.irq_o, (i == 5)); n_fail++; end
    end
    u_if.irq_raw_i = 1'b0;
    cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL window_raw_drop: got %b expected 0", u_if.irq_o); n_fail++; end
    go_idle();
  endtask

  task automatic test_urgent();
    cfg_holdoff_i = 16'd100; cfg_thresh_i = 4'd8;
    u_if.irq_raw_i = 1'b1; u_if.isr_id_i = 3'b010;
    cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL urgent_collect: got %b expected 0", u_if.irq_o); n_fail++; end
    u_if.isr_id_i = 3'b011;
    cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b1) begin $display("FAIL urgent_collect_fwd: got %b expected 1", u_if.irq_o); n_fail++; end
    cfg_holdoff_i = 16'd3;
    u_if.ack_i = 1'b1; cyc(1); u_if.ack_i = 1'b0;
    u_if.isr_id_i = 3'b010; cyc(1);
    u_if.isr_id_i = 3'b011; cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL urgent_holdoff_blocked: got %b expected 0", u_if.irq_o); n_fail++; end
    n_checks++; if (evt_cnt_o !== 4'd2) begin $display("FAIL urgent_holdoff_cnt: got %0d expected 2", evt_cnt_o); n_fail++; end
    for (int i = 1; i <= 3; i++) begin
      tick_once();
      n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL urgent_holdoff_tick[%0d]: got %b expected 0", i, u_if.irq_o); n_fail++; end
    end
    n_checks++; if (evt_cnt_o !== 4'd2) begin $display("FAIL urgent_reload_cnt: got %0d expected 2", evt_cnt_o); n_fail++; end
    cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b1) begin $display("FAIL urgent_after_holdoff: got %b expected 1", u_if.irq_o); n_fail++; end
    go_idle();
  endtask

  task automatic test_holdoff();
    cfg_holdoff_i = 16'd3; cfg_thresh_i = 4'd1;
    u_if.irq_raw_i = 1'b1; u_if.isr_id_i = 3'b010;
    cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b1) begin $display("FAIL holdoff_first_irq: got %b expected 1", u_if.irq_o); n_fail++; end
    u_if.ack_i = 1'b1; cyc(1); u_if.ack_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL holdoff_gap[%0d]: got %b expected 0", i, u_if.irq_o); n_fail++; end
      tick_once();
      n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL holdoff_tick[%0d]: got %b expected 0", i, u_if.irq_o); n_fail++; end
      n_checks++; if (evt_cnt_o !== ((i == 3) ? 4'd1 : 4'd0)) begin $display("FAIL holdoff_cnt[%0d]: got %0d expected %0d", i, evt_cnt_o, (i == 3) ? 1 : 0); n_fail++; end
    end
    cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b1) begin $display("FAIL holdoff_reirq: got %b expected 1", u_if.irq_o); n_fail++; end
    go_idle();
  endtask

  task automatic test_saturate();
    cfg_holdoff_i = 16'd100; cfg_thresh_i = 4'd1;
    u_if.irq_raw_i = 1'b1; u_if.isr_id_i = 3'b010;
    cyc(1);
    u_if.ack_i = 1'b1; cyc(1); u_if.ack_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      u_if.isr_id_i = (i % 2 == 0) ? 3'b110 : 3'b010;
      cyc(1);
    end
    n_checks++; if (evt_cnt_o !== 4'hF) begin $display("FAIL saturate_cnt: got %0d expected 15", evt_cnt_o); n_fail++; end
    n_checks++; if (u_if.irq_o !== 1'b0) begin $display("FAIL saturate_irq: got %b expected 0", u_if.irq_o); n_fail++; end
    go_idle();
  endtask

  task automatic test_holdoff_zero();
    cfg_holdoff_i = 16'd0; cfg_thresh_i = 4'd8;
    u_if.irq_raw_i = 1'b1; u_if.isr_id_i = 3'b010;
    cyc(1);
    n_checks++; if (u_if.irq_o !== 1'b1) begin $display("FAIL holdoff_zero_irq: got %b expected 1", u_if.irq_o); n_fail++; end
    go_idle();
  endtask

  task automatic test_stats();
    logic [15:0] exp_stats;
`ifdef OBI_UART_IRQ_MOD_STATS_EN
    exp_stats = 16'd8;
`else
    exp_stats = 16'd0;
`endif
    n_checks++; if (stats_irq_cnt_o !== exp_stats) begin $display("FAIL stats_cnt: got %0d expected %0d", stats_irq_cnt_o, exp_stats); n_fail++; end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tick_i = 1'b0; cfg_en_i = 1'b1;
    cfg_holdoff_i = 16'd0; cfg_thresh_i = 4'd0;
    u_if.irq_raw_i = 1'b0; u_if.isr_id_i = 3'b001; u_if.ack_i = 1'b0;
    test_reset();
    test_bypass();
    test_coalesce();
    test_window();
    test_urgent();
    test_holdoff();
    test_saturate();
    test_holdoff_zero();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
